// File: rtl/vec_pkg.sv
// Shared widths and result-word layout for the vector-logic result path.
package vec_pkg;

    localparam int unsigned OR_W  = 3;
    localparam int unsigned NOT_W = 6;
    localparam int unsigned RES_W = 10;

    // Packed MSB first: {or_bitwise, or_logical, not_ab}.
    typedef struct packed {
        logic [OR_W-1:0]  or_bitwise;
        logic             or_logical;
        logic [NOT_W-1:0] not_ab;
    } vec_result_t;

endpackage

// File: rtl/vec_result_fifo_mem.sv
// Storage array for vec_result_fifo: one write port, one asynchronous read port, no reset.
module vec_fifo_mem
    import vec_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  vec_result_t              wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output vec_result_t              rdata
);

    vec_result_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/vec_result_fifo.sv
// FWFT buffer for vector-logic result words with a saturating zero-result counter.
// Optional push-time consistency checker enabled by VEC_RESULT_CHECK_EN.
module vec_result_fifo
    import vec_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ZC_W  = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OR_W-1:0]          in_or_bitwise,
    input  logic                     in_or_logical,
    input  logic [NOT_W-1:0]         in_not,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RES_W-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [ZC_W-1:0]          zero_cnt,
    output logic                     err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ZC_W-1:0]  zero_cnt_q, zero_cnt_d;
    logic             push, pop;
    vec_result_t      in_word, rd_word;

    assign in_word   = '{or_bitwise: in_or_bitwise, or_logical: in_or_logical, not_ab: in_not};
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? RES_W'(rd_word) : '0;
    assign count     = count_q;
    assign zero_cnt  = zero_cnt_q;

    vec_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (in_word),
        .raddr (rd_ptr_q),
        .rdata (rd_word)
    );

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        zero_cnt_d = zero_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // Saturate rather than wrap so the consumer never sees a bogus small value.
        if (push && !in_or_logical && (zero_cnt_q != '1)) begin
            zero_cnt_d = zero_cnt_q + ZC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            zero_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            zero_cnt_q <= zero_cnt_d;
        end
    end

`ifdef VEC_RESULT_CHECK_EN
    logic err_q, err_d;
    logic chk_bad;

    // Recompute the unit's result from the inverted operands and compare.
    always_comb begin
        chk_bad = (in_or_bitwise != (~in_not[2:0] | ~in_not[5:3]))
               || (in_or_logical != (|in_or_bitwise));
        err_d   = err_q | (push & chk_bad);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_vec_result_fifo.sv
// Directed self-checking bench for vec_result_fifo (DEPTH=4; a second ZC_W=2 instance for saturation).
module tb_vec_result_fifo;

    logic       clk = 1'b0;
    logic       resetn;
    logic       in_valid;
    logic [2:0] in_or_bitwise;
    logic       in_or_logical;
    logic [5:0] in_not;
    logic       out_ready;

    logic       in_ready, out_valid, err;
    logic [9:0] out_data;
    logic [2:0] count;
    logic [7:0] zero_cnt;

    logic       in_ready2, out_valid2, err2;
    logic [9:0] out_data2;
    logic [2:0] count2;
    logic [1:0] zero_cnt2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    vec_result_fifo #(.DEPTH(4), .ZC_W(8)) u_dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_or_bitwise(in_or_bitwise), .in_or_logical(in_or_logical), .in_not(in_not),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .zero_cnt(zero_cnt), .err(err)
    );

    vec_result_fifo #(.DEPTH(4), .ZC_W(2)) u_dut_zc2 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready2),
        .in_or_bitwise(in_or_bitwise), .in_or_logical(in_or_logical), .in_not(in_not),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .count(count2), .zero_cnt(zero_cnt2), .err(err2)
    );

    // Well-formed result word of the upstream unit for operands a, b.
    function automatic logic [9:0] mk_word(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] o;
        o = a | b;
        return {o, |o, ~b, ~a};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [9:0] w, input logic v);
        {in_or_bitwise, in_or_logical, in_not} = w;
        in_valid = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [9:0] fill_w [4];
    logic [9:0] w;
    logic       exp_err;

    initial begin
        resetn    = 1'b0;
        out_ready = 1'b0;
        drive(mk_word(3'b011, 3'b100), 1'b1);
        step();
        step();
        check("rst_count", count, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_zero_cnt", zero_cnt, 0);
        check("rst_out_data", out_data, 0);
        check("rst_err", err, 0);

        resetn = 1'b1;
        drive(10'h000, 1'b0);
        step();
        check("idle_count", count, 0);

        // Single word, a=110 b=101.
        drive(mk_word(3'b110, 3'b101), 1'b1);
        check("single_word_model", mk_word(3'b110, 3'b101), 10'b111_1_010_001);
        step();
        drive(10'h000, 1'b0);
        check("single_out_valid", out_valid, 1);
        check("single_out_data", out_data, 10'b111_1_010_001);
        check("single_count", count, 1);
        out_ready = 1'b1;
        step();
        check("single_pop_count", count, 0);
        check("single_pop_out_valid", out_valid, 0);
        out_ready = 1'b0;

        // Fill to full with 5 offered words; the 5th must be refused.
        for (int i = 0; i < 5; i++) begin
            w = mk_word(3'(i + 1), 3'b000);
            if (i < 4) fill_w[i] = w;
            drive(w, 1'b1);
            check($sformatf("fill_in_ready_%0d", i), in_ready, (i < 4) ? 1 : 0);
            step();
        end
        drive(10'h000, 1'b0);
        check("full_count", count, 4);
        check("full_in_ready", in_ready, 0);

        // Drain; first pop offers a word while full, which must not enter.
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_data_%0d", i), out_data, fill_w[i]);
            out_ready = 1'b1;
            if (i == 0) drive(mk_word(3'b111, 3'b111), 1'b1);
            step();
            drive(10'h000, 1'b0);
            check($sformatf("drain_count_%0d", i), count, 3 - i);
        end
        out_ready = 1'b0;
        check("drain_out_valid", out_valid, 0);
        check("drain_out_data", out_data, 0);

        // Continuous stream: occupancy holds at 1, order preserved across pointer wrap.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            w = mk_word(3'((i % 7) + 1), 3'((i * 3) % 8));
            drive(w, 1'b1);
            step();
            check($sformatf("stream_data_%0d", i), out_data, w);
            check($sformatf("stream_count_%0d", i), count, 1);
        end
        drive(10'h000, 1'b0);
        step();
        check("stream_end_count", count, 0);
        check("pre_zero_cnt", zero_cnt, 0);

        // Zero counter: 3 zero words interleaved with 2 nonzero.
        for (int i = 0; i < 5; i++) begin
            w = (i % 2 == 0) ? mk_word(3'b000, 3'b000) : mk_word(3'b010, 3'b001);
            drive(w, 1'b1);
            step();
        end
        drive(10'h000, 1'b0);
        step();
        check("zero_word_model", mk_word(3'b000, 3'b000), 10'b000_0_111111);
        check("zero_cnt_3", zero_cnt, 3);
        check("zero_cnt2_3", zero_cnt2, 3);
        check("zero_count_empty", count, 0);

        for (int i = 0; i < 5; i++) begin
            drive(mk_word(3'b000, 3'b000), 1'b1);
            step();
        end
        drive(10'h000, 1'b0);
        step();
        check("zero_cnt_8", zero_cnt, 8);
        check("zero_cnt2_sat", zero_cnt2, 3);
        out_ready = 1'b0;

        // Inconsistent word: bitwise-OR 001 while both operands are 0.
        check("pre_bad_err", err, 0);
        drive(10'b001_1_111111, 1'b1);
        step();
        drive(10'h000, 1'b0);
`ifdef VEC_RESULT_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        check("bad_err", err, 32'(exp_err));
        check("bad_word_stored", out_data, 10'b001_1_111111);
        step();
        step();
        check("bad_err_sticky", err, 32'(exp_err));

        // Reset with words held discards them and clears err.
        drive(mk_word(3'b101, 3'b000), 1'b1);
        step();
        drive(10'h000, 1'b0);
        check("pre_reset_count", count, 2);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        check("midreset_count", count, 0);
        check("midreset_out_valid", out_valid, 0);
        check("midreset_err", err, 0);
        check("midreset_zero_cnt", zero_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vec_result_fifo.md
Name: vec_result_fifo

Overview:
- Downstream buffering stage for the 3-bit vector-logic unit.
- Accepts that unit's result word {or_bitwise[2:0], or_logical, not[5:0]} over a valid/ready handshake and holds up to DEPTH words in a first-word-fall-through FIFO.
- Keeps a saturating count of all-zero-operand results (or_logical==0) for the downstream consumer and for debug.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- ZC_W, 8, width of the zero-result counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- resetn  input  1  reset, synchronous, active-low.
- in_valid  input  1  upstream result word valid.
- in_ready  output  1  FIFO can accept a word this cycle.
- in_or_bitwise  input  3  bitwise-OR result.
- in_or_logical  input  1  logical-OR result.
- in_not  input  6  inverse of b in [5:3], inverse of a in [2:0].
- out_valid  output  1  head word available.
- out_ready  input  1  consumer takes head word.
- out_data  output  10  head word, packed {or_bitwise, or_logical, not}, MSB first.
- count  output  $clog2(DEPTH)+1  current occupancy.
- zero_cnt  output  ZC_W  saturating count of accepted words with in_or_logical==0.
- err  output  1  sticky consistency error; only active with the optional feature, otherwise tied 0.

Behaviour:
- Interface decision: single clock clk; reset resetn is synchronous, active-low.
- Reset is sampled at the clk edge when resetn==0. It clears:
  - wr_ptr, rd_ptr and count to 0
  - zero_cnt to 0
  - err to 0
- Reset outputs: out_valid=0, in_ready=1, out_data=0. Memory contents are not reset.
- Reset mid-operation discards all stored words with no drain. A handshake in the reset cycle has no effect.
- Handshake signals:
  - in_ready = (count != DEPTH).
  - push = in_valid & in_ready.
  - out_valid = (count != 0).
  - pop = out_valid & out_ready.
  - in_valid may assert independently of in_ready; the producer holds data stable until accepted.
- out_data = mem[rd_ptr] when count!=0, else 10'h000. It is combinational from registers (FWFT).
- Latency: a word pushed at edge N is visible on out_data/out_valid after edge N. There is no same-cycle bypass when empty.
- Full: in_ready=0 and no push, even if pop occurs in the same cycle. in_ready rises the cycle after the pop.
- Empty: out_valid=0; out_ready is ignored.
- Simultaneous push and pop (0<count<DEPTH): both pointers advance and count is unchanged.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
- zero_cnt increments on every push with in_or_logical==0 and saturates at 2^ZC_W-1. It is never decremented by pop.

Optional Feature:
- Macro: VEC_RESULT_CHECK_EN.
- Enabled: on each push, check in_or_bitwise == (~in_not[2:0] | ~in_not[5:3]) and in_or_logical == |in_or_bitwise.
  - Any mismatch sets err the cycle after the push; err stays set until reset.
  - The word is still stored unchanged.
- Disabled: no checker logic; err driven constant 0.

Decomposition:
- Package vec_pkg:
  - constants OR_W=3, NOT_W=6, RES_W=10
  - typedef vec_result_t, a packed struct {or_bitwise, or_logical, not_ab}
- Natural sub-module: vec_fifo_mem. Register array DEPTH x RES_W with one write port and one asynchronous read port, no reset.
- Top level holds pointers, count, handshake, zero_cnt and the checker.

Test Plan:
- Reset: resetn=0 for 2 cycles with in_valid=1 -> count=0, out_valid=0, in_ready=1, zero_cnt=0, out_data=0.
- Single word: push {3'b111,1,6'b010_001} (a=3'b110, b=3'b101) -> next cycle out_valid=1, out_data=10'b111_1_010_001; pop -> count=0.
- Fill/full: push 5 words back-to-back with out_ready=0, DEPTH=4.
  - in_ready drops after the 4th push and the 5th word is not accepted (count=4).
  - Then pop 4 words -> order preserved, 4th pop leaves out_valid=0.
- Wrap plus simultaneous push/pop: stream 10 words with in_valid=out_ready=1 continuously -> count holds at 1 after the first push, all 10 emerge in order, pointers wrap.
- Zero counter: push 3 words with a=b=0 ({000,0,111111}) and 2 nonzero words -> zero_cnt=3. With ZC_W=2, push 5 zero words -> zero_cnt saturates at 3.
- Checker (VEC_RESULT_CHECK_EN): push {3'b001,1,6'b111_111} -> err=1 next cycle and stays 1. Without the macro, err stays 0.
